// File: rtl/ecc_pkg.sv
// Shared constants, types and width helpers for the ECC read-path post-processor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ecc_pkg;

  // Decoder failing-bit codes with special meaning
  localparam logic [3:0] ERR_NONE = 4'hf;
  localparam logic [3:0] ERR_PAR  = 4'hc;

  // Error-log entry width: {addr, is_db, err_addr[3:0]}
  function automatic int LOG_W(input int addr_w);
    return addr_w + 5;
  endfunction

  // Write-back (scrub) request FSM
  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_REQ  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/ecc_log_fifo.sv
// Synchronous FIFO for error-log entries; push/pop with full, empty and drop-on-full flags.
// Latency: an entry pushed into an empty FIFO is visible at the head 1 cycle later.
// Backpressure: a push while full is dropped (drop_o) unless a pop happens the same cycle.
module ecc_log_fifo #(
  parameter int W     = 15,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic         pop_ok, push_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands
  assign push_ok = push_i && (!full_o || pop_ok);
  assign drop_o  = push_i && !push_ok;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance on accepted push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Registers decoded MRAM reads, counts SB/DB errors, logs error events and issues scrub write-backs.
// Latency: rd_*, counters, wb_req_o and log_vld_o all react 1 cycle after the decoder event.
// Backpressure: none on the read stage; scrubs while a request is pending and log pushes into a full FIFO are dropped and flagged.
module ecc_scrub_ctrl
  import ecc_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int CNT_W     = 16,
  parameter int LOG_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      dec_vld_i,
  input  logic [ADDR_W-1:0]         dec_addr_i,
  input  logic [7:0]                dec_q_i,
  input  logic                      dec_sb_err_i,
  input  logic                      dec_db_err_i,
  input  logic [3:0]                dec_err_addr_i,
  output logic                      rd_vld_o,
  output logic [7:0]                rd_data_o,
  output logic                      rd_err_o,
  input  logic                      scrub_en_i,
  output logic                      wb_req_o,
  input  logic                      wb_ack_i,
  output logic [ADDR_W-1:0]         wb_addr_o,
  output logic [7:0]                wb_data_o,
  output logic                      wb_miss_o,
  output logic [CNT_W-1:0]          sb_cnt_o,
  output logic [CNT_W-1:0]          db_cnt_o,
  output logic                      log_vld_o,
  input  logic                      log_rdy_i,
  output logic [LOG_W(ADDR_W)-1:0]  log_data_o,
  output logic                      log_ovf_o,
  input  logic                      clr_i
);

  localparam int          LW      = LOG_W(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic              is_sb, is_db;
  logic              rd_vld_q, rd_err_q;
  logic [7:0]        rd_data_q;
  logic [CNT_W-1:0]  sb_cnt_q, sb_cnt_d, db_cnt_q, db_cnt_d;
  wb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [7:0]        wb_data_q, wb_data_d;
  logic              miss_set;
  logic              miss_q, miss_d, ovf_q, ovf_d;
  logic              log_empty, log_drop, unused_log_full;
  logic [LW-1:0]     log_head;

  // DB dominates: a word flagged both SB and DB is treated as uncorrectable
  assign is_db = dec_vld_i && dec_db_err_i;
  assign is_sb = dec_vld_i && dec_sb_err_i && !dec_db_err_i;

  // Read stage: data held between valid words, error flag only for DB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      rd_vld_q <= dec_vld_i;
      rd_err_q <= is_db;
      if (dec_vld_i) rd_data_q <= dec_q_i;
    end
  end

  // Saturating counters and sticky flags; clear wins over a same-cycle event
  always_comb begin
    sb_cnt_d = sb_cnt_q;
    db_cnt_d = db_cnt_q;
    miss_d   = miss_q || miss_set;
    ovf_d    = ovf_q || log_drop;
    if (clr_i) begin
      sb_cnt_d = '0;
      db_cnt_d = '0;
      miss_d   = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      if (is_sb && !(&sb_cnt_q)) sb_cnt_d = sb_cnt_q + CNT_ONE;
      if (is_db && !(&db_cnt_q)) db_cnt_d = db_cnt_q + CNT_ONE;
    end
  end

  // Write-back FSM next state; check-bit errors (8..12) scrub too since rewriting regenerates them
  always_comb begin
    state_d   = state_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    miss_set  = 1'b0;
    case (state_q)
      WB_IDLE: begin
        if (is_sb && scrub_en_i) begin
          state_d   = WB_REQ;
          wb_addr_d = dec_addr_i;
          wb_data_d = dec_q_i;
        end
      end
      WB_REQ: begin
        miss_set = is_sb;
        if (wb_ack_i) state_d = WB_IDLE;
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // State, counter and sticky-flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WB_IDLE;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      sb_cnt_q  <= '0;
      db_cnt_q  <= '0;
      miss_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      sb_cnt_q  <= sb_cnt_d;
      db_cnt_q  <= db_cnt_d;
      miss_q    <= miss_d;
      ovf_q     <= ovf_d;
    end
  end

  // Full is implied by the FIFO's own drop flag at this level
  ecc_log_fifo #(
    .W     (LW),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (is_sb || is_db),
    .din_i   ({dec_addr_i, is_db, dec_err_addr_i}),
    .pop_i   (log_rdy_i),
    .dout_o  (log_head),
    .full_o  (unused_log_full),
    .empty_o (log_empty),
    .drop_o  (log_drop)
  );

  assign rd_vld_o   = rd_vld_q;
  assign rd_data_o  = rd_data_q;
  assign rd_err_o   = rd_err_q;
  assign wb_req_o   = (state_q == WB_REQ);
  assign wb_addr_o  = wb_addr_q;
  assign wb_data_o  = wb_data_q;
  assign wb_miss_o  = miss_q;
  assign sb_cnt_o   = sb_cnt_q;
  assign db_cnt_o   = db_cnt_q;
  assign log_vld_o  = !log_empty;
  // Stale storage is hidden while the log is empty
  assign log_data_o = log_empty ? '0 : log_head;
  assign log_ovf_o  = ovf_q;

endmodule

// File: doc/ecc_scrub_ctrl.md
# ecc_scrub_ctrl

Read-path post-processor that sits directly downstream of the 13-bit SECDED decoder on the MRAM read path. It registers the decoded byte and flags toward the host, keeps saturating error statistics, and logs each error event into a small FIFO. Each correctable error also raises a write-back request, so the corrected byte is re-encoded and rewritten to the failing address (scrub).

## Interface
Parameters:
- ADDR_W, 10, word address width
- CNT_W, 16, width of each saturating error counter
- LOG_DEPTH, 4, error-log FIFO depth (power of two, ≥2)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- dec_vld_i  in  1  decoder outputs valid this cycle (one word per pulse)
- dec_addr_i  in  ADDR_W  word address of the decoded codeword
- dec_q_i  in  8  corrected data byte from decoder
- dec_sb_err_i  in  1  single-bit (correctable) error
- dec_db_err_i  in  1  double-bit (uncorrectable) error
- dec_err_addr_i  in  4  failing bit: 0–7 data, 8–11 check, 12 overall parity, 15 none
- rd_vld_o  out  1  registered read-data valid
- rd_data_o  out  8  registered data byte
- rd_err_o  out  1  registered uncorrectable flag
- scrub_en_i  in  1  enables write-back on correctable errors
- wb_req_o  out  1  write-back request, held until acknowledged
- wb_ack_i  in  1  write-back accepted
- wb_addr_o  out  ADDR_W  write-back address
- wb_data_o  out  8  write-back byte (re-encoded by the write path)
- wb_miss_o  out  1  sticky: scrub dropped because a request was pending
- sb_cnt_o  out  CNT_W  saturating correctable-error count
- db_cnt_o  out  CNT_W  saturating uncorrectable-error count
- log_vld_o  out  1  log FIFO non-empty
- log_rdy_i  in  1  consumer pops head entry when log_vld_o is also high
- log_data_o  out  ADDR_W+5  {addr, is_db, err_addr[3:0]}
- log_ovf_o  out  1  sticky: log entry dropped because the FIFO was full
- clr_i  in  1  clears counters, wb_miss_o and log_ovf_o (FIFO untouched)

## Operation
- Classification at dec_vld_i:
  - If dec_db_err_i is set, the word is DB, even when dec_sb_err_i is also set.
  - Otherwise, if dec_sb_err_i is set, the word is SB.
  - Otherwise the word is CLEAN.
- Read stage: rd_vld_o/rd_data_o/rd_err_o are registered from the dec_* inputs. rd_err_o=1 only for DB.
- Counters:
  - sb_cnt_o increments on SB, db_cnt_o increments on DB.
  - Both saturate at all-ones.
  - clr_i has priority over a same-cycle increment; the result is 0.
- Log:
  - Every SB or DB event pushes {dec_addr_i, is_db, dec_err_addr_i}. CLEAN words push nothing.
  - A push into a full FIFO is dropped and sets log_ovf_o, unless a pop happens in the same cycle; pop plus push when full succeeds.
- Write-back FSM, two states:
  - IDLE: an SB event with scrub_en_i=1 captures addr/data and moves to REQ. This includes err_addr 8–12: stored check bits are wrong, and rewriting the data regenerates them.
  - REQ: wb_req_o=1 and wb_addr_o/wb_data_o are held stable. wb_ack_i returns the FSM to IDLE. An SB event while in REQ, in any cycle including the ack cycle, is not captured and sets wb_miss_o.
  - DB events never scrub.
- scrub_en_i deasserting while in REQ does not cancel the pending request.

## Timing
- Every output resets to 0, except the FIFO, which is empty.
- rd_* and counter updates appear 1 cycle after dec_vld_i.
- wb_req_o rises 1 cycle after the SB event. It falls on the cycle after wb_ack_i is sampled high.
- log_vld_o rises 1 cycle after a push into an empty FIFO. log_data_o is the head entry and is stable while log_vld_o=1 and log_rdy_i=0.
- dec_vld_i may be asserted every cycle; there is no backpressure on the read stage.
- Reset mid-request drops the pending write-back and clears the FIFO.

## Structure
- Shared package ecc_pkg:
  - ERR_NONE=4'hf, ERR_PAR=4'hc
  - LOG_W(ADDR_W) width helper
  - write-back FSM state enum
- Sub-module ecc_log_fifo: synchronous FIFO, parameterised width/depth, with push/pop, full/empty and drop-on-full outputs.

## Test plan
- Three CLEAN words at addresses 1, 2, 3 → rd_vld_o pulses 1 cycle later with matching data; rd_err_o=0; counters stay 0; FIFO empty; wb_req_o=0.
- SB at addr 0x05, data 0xA5, err_addr 3, scrub_en_i=1 → sb_cnt_o=1; log entry {0x05,0,3}; wb_req_o high with addr 0x05, data 0xA5 until wb_ack_i, which is held off for 4 cycles.
- DB at addr 0x10 → rd_err_o=1; db_cnt_o=1; log entry {0x10,1,0xf}; no wb_req_o.
- Two back-to-back SB events while the first request is unacknowledged → one request only; wb_miss_o=1; sb_cnt_o=2; clr_i then zeroes the counters and wb_miss_o.
- Five error events with log_rdy_i=0, LOG_DEPTH=4 → four entries retained; log_ovf_o=1. A fifth push coinciding with a pop when full → accepted, no new drop.
- Preload sb_cnt to all-ones (force) followed by one SB event → count stays all-ones; assert rst_n low during REQ → all outputs 0 asynchronously.
